// File: rtl/lzd_pkg.sv
// lzd_pkg: shared constants and elaboration-time helpers for the pipelined
// leading-zero/leading-one detector (lzd_pipe).
//   LZD_MODE_ZEROS / LZD_MODE_ONES : values of mode_i
//   lzd_clog2(value)               : ceil(log2(value)), 0 for value <= 1
//   lzd_nseg(swr, seg)             : number of stage-1 segments, ceil(swr/seg)
package lzd_pkg;

    localparam logic LZD_MODE_ZEROS = 1'b0;
    localparam logic LZD_MODE_ONES  = 1'b1;

    function automatic int unsigned lzd_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned lzd_nseg(input int unsigned swr, input int unsigned seg);
        return (swr + seg - 1) / seg;
    endfunction

endpackage

// File: rtl/lzd_pipe_if.sv
// lzd_pipe_if: handshake/data bundle of lzd_pipe.
//   Input side : in_valid_i, in_ready_o, mode_i, data_i[SWR-1:0]
//   Output side: out_valid_o, out_ready_i, shift_o[EWR-1:0], zero_o,
//                data_o[SWR-1:0] (only when LZD_DATA_PASS_EN is defined)
//   slave  modport: the detector itself
//   master modport: the producer/consumer surrounding it
interface lzd_pipe_if #(
    parameter int unsigned SWR = 26,
    parameter int unsigned EWR = 5
);

    logic           in_valid_i;
    logic           in_ready_o;
    logic           mode_i;
    logic [SWR-1:0] data_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [EWR-1:0] shift_o;
    logic           zero_o;
`ifdef LZD_DATA_PASS_EN
    logic [SWR-1:0] data_o;
`endif

    modport slave (
        input  in_valid_i,
        input  mode_i,
        input  data_i,
        input  out_ready_i,
`ifdef LZD_DATA_PASS_EN
        output data_o,
`endif
        output in_ready_o,
        output out_valid_o,
        output shift_o,
        output zero_o
    );

    modport master (
        output in_valid_i,
        output mode_i,
        output data_i,
        output out_ready_i,
`ifdef LZD_DATA_PASS_EN
        input  data_o,
`endif
        input  in_ready_o,
        input  out_valid_o,
        input  shift_o,
        input  zero_o
    );

endinterface

// File: rtl/lzd_seg_enc.sv
// lzd_seg_enc: combinational SEG-bit priority encoder used per segment in
// stage 1 of lzd_pipe. Bit SEG-1 is the segment MSB.
//   i_seg      : segment bits
//   o_cnt      : zeros above the highest set bit (0 when o_seg_zero)
//   o_seg_zero : no bit set in the segment
module lzd_seg_enc #(
    parameter int unsigned SEG = 8,
    parameter int unsigned CW  = 3
) (
    input  logic [SEG-1:0] i_seg,
    output logic [CW-1:0]  o_cnt,
    output logic           o_seg_zero
);

    always_comb begin
        o_cnt      = '0;
        o_seg_zero = 1'b1;
        // Scan LSB to MSB so the highest set bit is the last one written.
        for (int i = 0; i < int'(SEG); i++) begin
            if (i_seg[i]) begin
                o_cnt      = CW'(int'(SEG) - 1 - i);
                o_seg_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lzd_pipe.sv
// lzd_pipe: two-stage pipelined leading-zero / leading-one detector for the FP
// add/sub normalisation path, with valid/ready flow control.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, discards in-flight words
//   bus  : lzd_pipe_if slave (in_valid_i/in_ready_o/mode_i/data_i,
//          out_valid_o/out_ready_i/shift_o/zero_o[/data_o])
// Optional feature macro LZD_DATA_PASS_EN: carries data_i (uninverted) along
// with the count and presents it on data_o.
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter int unsigned SWR = 26,
    parameter int unsigned EWR = 5,
    parameter int unsigned SEG = 8
) (
    input  logic        clk,
    input  logic        rst,
    lzd_pipe_if.slave   bus
);

    localparam int unsigned NSEG = lzd_nseg(SWR, SEG);
    localparam int unsigned PADW = NSEG * SEG;
    localparam int unsigned CW   = (lzd_clog2(SEG) < 1) ? 1 : lzd_clog2(SEG);

    if ((2 ** EWR) <= SWR) begin : g_ewr_check
        $error("lzd_pipe: EWR too small, need 2**EWR > SWR");
    end

    // ---------------- flow control ----------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_adv;
    logic w_s2_adv;

    assign w_s2_adv       = !r_s2_valid || bus.out_ready_i;
    assign w_s1_adv       = !r_s1_valid || w_s2_adv;
    assign bus.in_ready_o = w_s1_adv;

    // ---------------- stage 1: per-segment encode ----------------
    logic [PADW-1:0]          w_padded;
    logic [NSEG-1:0][CW-1:0]  w_seg_cnt;
    logic [NSEG-1:0]          w_seg_zero;
    logic [NSEG-1:0][CW-1:0]  r_seg_cnt;
    logic [NSEG-1:0]          r_seg_zero;

    // Leading-one detection is leading-zero detection of the inverted word, so
    // mode is fully absorbed here and is not needed by stage 2. Padding ones
    // terminate the count at exactly SWR for an all-zero word.
    always_comb begin
        w_padded             = '1;
        w_padded[PADW-1 -: SWR] = (bus.mode_i == LZD_MODE_ONES) ? ~bus.data_i : bus.data_i;
    end

    // Segment 0 is the most significant one.
    for (genvar g = 0; g < int'(NSEG); g++) begin : g_seg
        lzd_seg_enc #(
            .SEG (SEG),
            .CW  (CW)
        ) u_seg_enc (
            .i_seg      (w_padded[PADW-1-g*SEG -: SEG]),
            .o_cnt      (w_seg_cnt[g]),
            .o_seg_zero (w_seg_zero[g])
        );
    end

    // ---------------- stage 2: segment select ----------------
    logic [EWR-1:0] w_shift;
    logic           w_zero;
    logic [EWR-1:0] r_shift;
    logic           r_zero;

    always_comb begin
        w_shift = EWR'(SWR);
        // Scan from the LSB segment upward so the most significant non-empty
        // segment wins.
        for (int i = int'(NSEG) - 1; i >= 0; i--) begin
            if (!r_seg_zero[i]) begin
                w_shift = EWR'(i * int'(SEG) + int'(r_seg_cnt[i]));
            end
        end
        w_zero = (w_shift == EWR'(SWR));
    end

`ifdef LZD_DATA_PASS_EN
    logic [SWR-1:0] r_s1_data;
    logic [SWR-1:0] r_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_seg_cnt  <= '0;
            r_seg_zero <= '0;
            r_shift    <= '0;
            r_zero     <= 1'b0;
`ifdef LZD_DATA_PASS_EN
            r_s1_data  <= '0;
            r_data     <= '0;
`endif
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    r_seg_cnt  <= w_seg_cnt;
                    r_seg_zero <= w_seg_zero;
`ifdef LZD_DATA_PASS_EN
                    r_s1_data  <= bus.data_i;
`endif
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_shift <= w_shift;
                    r_zero  <= w_zero;
`ifdef LZD_DATA_PASS_EN
                    r_data  <= r_s1_data;
`endif
                end
            end
        end
    end

    assign bus.out_valid_o = r_s2_valid;
    assign bus.shift_o     = r_shift;
    assign bus.zero_o      = r_zero;
`ifdef LZD_DATA_PASS_EN
    assign bus.data_o      = r_data;
`endif

endmodule

// File: tb/tb_lzd_pipe.sv
// tb_lzd_pipe: self-checking bench for lzd_pipe, single precision (SWR=26)
// and double precision (SWR=55) instances, against a bit-scanning model.
module tb_lzd_pipe;

    typedef struct {
        int          shift;
        int          zero;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lzd_pipe_if #(.SWR(26), .EWR(5)) b26 ();
    lzd_pipe_if #(.SWR(55), .EWR(6)) b55 ();

    lzd_pipe #(.SWR(26), .EWR(5), .SEG(8)) u_dut26 (.clk(clk), .rst(rst), .bus(b26));
    lzd_pipe #(.SWR(55), .EWR(6), .SEG(8)) u_dut55 (.clk(clk), .rst(rst), .bus(b55));

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q26[$];
    exp_t q55[$];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk down from the MSB counting bits equal to the mode value.
    function automatic exp_t ref_model(input logic [63:0] d, input int w, input bit m);
        exp_t r;
        int   n;
        bit   found;
        n     = 0;
        found = 1'b0;
        for (int b = w - 1; b >= 0; b--) begin
            if (!found) begin
                if (d[b] != m) found = 1'b1;
                else           n++;
            end
        end
        r.shift = n;
        r.zero  = found ? 0 : 1;
        r.data  = d;
        return r;
    endfunction

    task automatic step26(input bit v, input bit m, input logic [25:0] d, input bit ordy,
                          output bit acc, output bit got);
        exp_t e;
        @(negedge clk);
        b26.in_valid_i  = v;
        b26.mode_i      = m;
        b26.data_i      = d;
        b26.out_ready_i = ordy;
        #1;
        acc = v && b26.in_ready_o;
        got = b26.out_valid_o && ordy;
        if (b26.out_valid_o) begin
            check_eq("s26_pending", longint'(q26.size() != 0), 1);
            if (q26.size() != 0) begin
                e = q26[0];
                check_eq("s26_shift", b26.shift_o, e.shift);
                check_eq("s26_zero", b26.zero_o, e.zero);
`ifdef LZD_DATA_PASS_EN
                check_eq("s26_data", b26.data_o, e.data);
`endif
                if (ordy) void'(q26.pop_front());
            end
        end
        if (acc) q26.push_back(ref_model(64'(d), 26, m));
    endtask

    task automatic step55(input bit v, input bit m, input logic [54:0] d, input bit ordy);
        exp_t e;
        @(negedge clk);
        b55.in_valid_i  = v;
        b55.mode_i      = m;
        b55.data_i      = d;
        b55.out_ready_i = ordy;
        #1;
        if (b55.out_valid_o) begin
            check_eq("s55_pending", longint'(q55.size() != 0), 1);
            if (q55.size() != 0) begin
                e = q55[0];
                check_eq("s55_shift", b55.shift_o, e.shift);
                check_eq("s55_zero", b55.zero_o, e.zero);
`ifdef LZD_DATA_PASS_EN
                check_eq("s55_data", b55.data_o, e.data);
`endif
                if (ordy) void'(q55.pop_front());
            end
        end
        if (v && b55.in_ready_o) q55.push_back(ref_model(64'(d), 55, m));
    endtask

    task automatic drain26();
        bit a, g;
        for (int i = 0; i < 12 && q26.size() != 0; i++) step26(1'b0, 1'b0, '0, 1'b1, a, g);
        check_eq("drain26_empty", q26.size(), 0);
    endtask

    task automatic drain55();
        for (int i = 0; i < 12 && q55.size() != 0; i++) step55(1'b0, 1'b0, '0, 1'b1);
        check_eq("drain55_empty", q55.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a, g;
        int          k, outs, cyc;
        logic [25:0] words [4];
        logic [25:0] d26;
        logic [54:0] d55;
        bit          m;

        b26.in_valid_i = 1'b0; b26.mode_i = 1'b0; b26.data_i = '0; b26.out_ready_i = 1'b0;
        b55.in_valid_i = 1'b0; b55.mode_i = 1'b0; b55.data_i = '0; b55.out_ready_i = 1'b0;

        // Reset state
        #12;
        check_eq("rst_out_valid", b26.out_valid_o, 0);
        check_eq("rst_shift", b26.shift_o, 0);
        check_eq("rst_zero", b26.zero_o, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_in_ready", b26.in_ready_o, 1);

        // Single word, latency 2
        step26(1'b1, 1'b0, 26'h0800000, 1'b1, a, g);
        check_eq("t1_accept", a, 1);
        step26(1'b0, 1'b0, '0, 1'b1, a, g);
        check_eq("t1_lat1_valid", b26.out_valid_o, 0);
        step26(1'b0, 1'b0, '0, 1'b1, a, g);
        check_eq("t1_lat2_valid", g, 1);

        // All-zero word and LSB-only word; leading ones
        step26(1'b1, 1'b0, 26'h0000000, 1'b1, a, g);
        step26(1'b1, 1'b0, 26'h0000001, 1'b1, a, g);
        step26(1'b1, 1'b1, 26'h3FFFFF0, 1'b1, a, g);
        step26(1'b1, 1'b1, 26'h3FFFFFF, 1'b1, a, g);
        drain26();

        // Backpressure: 4 words, out_ready low for 5 cycles
        words[0] = 26'h1 << 25; words[1] = 26'h1 << 20;
        words[2] = 26'h1 << 9;  words[3] = 26'h1;
        k = 0;
        for (cyc = 0; cyc < 5; cyc++) begin
            step26(k < 4, 1'b0, words[k < 4 ? k : 3], 1'b0, a, g);
            if (a) k++;
            if (cyc == 2) check_eq("bp_in_ready_low", b26.in_ready_o, 0);
        end
        check_eq("bp_accepts", k, 2);
        outs = 0;
        for (cyc = 0; cyc < 12 && outs < 4; cyc++) begin
            step26(k < 4, 1'b0, words[k < 4 ? k : 3], 1'b1, a, g);
            if (a) k++;
            if (g) outs++;
        end
        check_eq("bp_outs", outs, 4);
        check_eq("bp_no_gaps", cyc, 4);
        drain26();

        // Asynchronous reset with both stages full
        step26(1'b1, 1'b0, 26'h0002000, 1'b0, a, g);
        step26(1'b1, 1'b0, 26'h0002000, 1'b0, a, g);
        step26(1'b0, 1'b0, '0, 1'b0, a, g);
        check_eq("rst_mid_full", b26.out_valid_o, 1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("rst_mid_valid", b26.out_valid_o, 0);
        check_eq("rst_mid_shift", b26.shift_o, 0);
        q26.delete();
        q55.delete();
        @(negedge clk);
        rst = 1'b1;
        step26(1'b1, 1'b0, 26'h0000400, 1'b1, a, g);
        step26(1'b0, 1'b0, '0, 1'b1, a, g);
        check_eq("rst_post_lat1", b26.out_valid_o, 0);
        step26(1'b0, 1'b0, '0, 1'b1, a, g);
        check_eq("rst_post_lat2", g, 1);

        // Random sweep, SWR=26
        for (int i = 0; i < 300; i++) begin
            m   = 1'($urandom);
            d26 = 26'($urandom) >> $urandom_range(0, 26);
            if (m) d26 = ~d26;
            step26(1'($urandom_range(0, 3) != 0), m, d26, 1'($urandom_range(0, 3) != 0), a, g);
        end
        drain26();

        // SWR=55 directed and random
        step55(1'b1, 1'b0, 55'h1, 1'b1);
        step55(1'b1, 1'b0, 55'h1 << 47, 1'b1);
        step55(1'b1, 1'b0, '0, 1'b1);
        step55(1'b1, 1'b1, '1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            m   = 1'($urandom);
            d55 = 55'({$urandom, $urandom}) >> $urandom_range(0, 55);
            if (m) d55 = ~d55;
            step55(1'($urandom_range(0, 3) != 0), m, d55, 1'($urandom_range(0, 3) != 0));
        end
        drain55();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
